// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-32 pipeline constants, IF/ID action encoding and PC alignment helper
package mips_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_ALIGN      = 2;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IFID_RESET,
        IFID_FLUSH,
        IFID_HOLD,
        IFID_BUBBLE,
        IFID_FETCH
    } ifid_action_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
    endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with reset/redirect/hold/increment priority
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        pcwrite_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    // Redirect beats any hold; an unfinished fetch keeps the PC on the same word.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_pc(redirect_target_i);
        end else if (pcwrite_i && imem_ready_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS-32 instruction fetch stage with IF/ID register and perf counters
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pcwrite_i,
    input  logic             if_id_write_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_target_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_ready_i,
    output logic [31:0]      if_id_instr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic             fetch_stall_o,
    output logic [CNT_W-1:0] perf_fetch_cnt_o,
    output logic [CNT_W-1:0] perf_bubble_cnt_o
);

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    ifid_action_e     action;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .pcwrite_i         (pcwrite_i),
        .imem_ready_i      (imem_ready_i),
        .pc_o              (pc),
        .pc_plus4_o        (pc_plus4)
    );

    assign imem_addr_o   = pc;
    assign imem_req_o    = !rst_i;
    assign fetch_stall_o = imem_req_o && !imem_ready_i;

    // A flush must win over an ID-stage hold so a squashed instruction never survives.
    always_comb begin
        action = IFID_FETCH;
        if (rst_i) begin
            action = IFID_RESET;
        end else if (redirect_i) begin
            action = IFID_FLUSH;
        end else if (!if_id_write_i) begin
            action = IFID_HOLD;
        end else if (!imem_ready_i) begin
            action = IFID_BUBBLE;
        end
    end

    always_comb begin
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        case (action)
            IFID_RESET, IFID_FLUSH, IFID_BUBBLE: begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
            IFID_FETCH: begin
                instr_d = imem_rdata_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
            default: ;
        endcase
        if (action == IFID_FETCH && fetch_cnt_q != {CNT_W{1'b1}}) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
        if ((action == IFID_FLUSH || action == IFID_BUBBLE) && bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign if_id_instr_o     = instr_q;
    assign if_id_pc4_o       = pc4_q;
    assign if_id_valid_o     = valid_q;
    assign perf_fetch_cnt_o  = fetch_cnt_q;
    assign perf_bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage (16-bit and 4-bit counter instances)
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcwrite;
    logic        if_id_write;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_ready;

    logic        imem_req, fetch_stall, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
    logic [15:0] fcnt, bcnt;

    logic        imem_req4, fetch_stall4, if_id_valid4;
    logic [31:0] imem_addr4, imem_rdata4, if_id_instr4, if_id_pc44;
    logic [3:0]  fcnt4, bcnt4;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata  = instr_at(imem_addr);
    assign imem_rdata4 = instr_at(imem_addr4);

    if_fetch_stage #(.CNT_W(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pcwrite_i         (pcwrite),
        .if_id_write_i     (if_id_write),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_rdata_i      (imem_rdata),
        .imem_ready_i      (imem_ready),
        .if_id_instr_o     (if_id_instr),
        .if_id_pc4_o       (if_id_pc4),
        .if_id_valid_o     (if_id_valid),
        .fetch_stall_o     (fetch_stall),
        .perf_fetch_cnt_o  (fcnt),
        .perf_bubble_cnt_o (bcnt)
    );

    if_fetch_stage #(.CNT_W(4)) dut4 (
        .clk_i             (clk),
        .rst_i             (rst),
        .pcwrite_i         (pcwrite),
        .if_id_write_i     (if_id_write),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .imem_req_o        (imem_req4),
        .imem_addr_o       (imem_addr4),
        .imem_rdata_i      (imem_rdata4),
        .imem_ready_i      (imem_ready),
        .if_id_instr_o     (if_id_instr4),
        .if_id_pc4_o       (if_id_pc44),
        .if_id_valid_o     (if_id_valid4),
        .fetch_stall_o     (fetch_stall4),
        .perf_fetch_cnt_o  (fcnt4),
        .perf_bubble_cnt_o (bcnt4)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        req;
        logic        stall;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] fcnt;
        logic [15:0] bcnt;
        logic [3:0]  fcnt4;
        logic [3:0]  bcnt4;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        if ($isunknown(exp)) return;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected just after the next edge.
    task automatic step(input string name, input logic r, input logic pw, input logic iw,
                        input logic rd, input logic [31:0] tgt, input logic rdy,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_v, input int e_f, input int e_b);
        exp_t e;
        rst = r; pcwrite = pw; if_id_write = iw;
        redirect = rd; redirect_target = tgt; imem_ready = rdy;
        e.name = name; e.pc = e_pc; e.req = !r; e.stall = !r && !rdy;
        e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_v;
        e.fcnt = 16'(e_f); e.bcnt = 16'(e_b);
        e.fcnt4 = sat4(e_f); e.bcnt4 = sat4(e_b);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, "imem_addr",   imem_addr,         mon_e.pc);
                chk(mon_e.name, "imem_req",    {31'b0, imem_req},    {31'b0, mon_e.req});
                chk(mon_e.name, "fetch_stall", {31'b0, fetch_stall}, {31'b0, mon_e.stall});
                chk(mon_e.name, "instr",       if_id_instr,       mon_e.instr);
                chk(mon_e.name, "pc4",         if_id_pc4,         mon_e.pc4);
                chk(mon_e.name, "valid",       {31'b0, if_id_valid}, {31'b0, mon_e.valid});
                chk(mon_e.name, "fetch_cnt",   {16'b0, fcnt},     {16'b0, mon_e.fcnt});
                chk(mon_e.name, "bubble_cnt",  {16'b0, bcnt},     {16'b0, mon_e.bcnt});
                chk(mon_e.name, "fetch_cnt4",  {28'b0, fcnt4},    {28'b0, mon_e.fcnt4});
                chk(mon_e.name, "bubble_cnt4", {28'b0, bcnt4},    {28'b0, mon_e.bcnt4});
            end
        end
    end

    initial begin
        //   name       rst pw iw rd target        rdy  pc            instr                  pc4           v  f  b
        step("reset0",   1, 1, 1, 0, 32'h0,        1,   32'h0,        32'h0,                 32'h0,        0, 0, 0);
        step("reset1",   1, 1, 1, 0, 32'h0,        1,   32'h0,        32'h0,                 32'h0,        0, 0, 0);
        step("run_0",    0, 1, 1, 0, 32'h0,        1,   32'h4,        instr_at(32'h0),       32'h4,        1, 1, 0);
        step("run_4",    0, 1, 1, 0, 32'h0,        1,   32'h8,        instr_at(32'h4),       32'h8,        1, 2, 0);
        step("loaduse",  0, 0, 0, 0, 32'h0,        1,   32'h8,        instr_at(32'h4),       32'h8,        1, 2, 0);
        step("run_8",    0, 1, 1, 0, 32'h0,        1,   32'hC,        instr_at(32'h8),       32'hC,        1, 3, 0);
        step("run_c",    0, 1, 1, 0, 32'h0,        1,   32'h10,       instr_at(32'hC),       32'h10,       1, 4, 0);
        step("redir",    0, 1, 1, 1, 32'h103,      1,   32'h100,      32'h0,                 32'h0,        0, 4, 1);
        step("redir_hold",0,0, 0, 1, 32'h13,       1,   32'h10,       32'h0,                 32'h0,        0, 4, 2);
        step("run_10",   0, 1, 1, 0, 32'h0,        1,   32'h14,       instr_at(32'h10),      32'h14,       1, 5, 2);
        step("wait0",    0, 1, 1, 0, 32'h0,        0,   32'h14,       32'h0,                 32'bx,        0, 5, 3);
        step("wait1",    0, 1, 1, 0, 32'h0,        0,   32'h14,       32'h0,                 32'bx,        0, 5, 4);
        step("wait2",    0, 1, 1, 0, 32'h0,        0,   32'h14,       32'h0,                 32'bx,        0, 5, 5);
        step("run_14",   0, 1, 1, 0, 32'h0,        1,   32'h18,       instr_at(32'h14),      32'h18,       1, 6, 5);
        step("hold_wait",0, 0, 0, 0, 32'h0,        0,   32'h18,       instr_at(32'h14),      32'h18,       1, 6, 5);
        step("rst_wait", 1, 1, 1, 0, 32'h0,        0,   32'h0,        32'h0,                 32'h0,        0, 0, 0);
        step("post_rst", 0, 1, 1, 0, 32'h0,        1,   32'h4,        instr_at(32'h0),       32'h4,        1, 1, 0);
        step("redir_top",0, 1, 1, 1, 32'hFFFF_FFF8,1,   32'hFFFF_FFF8,32'h0,                 32'h0,        0, 1, 1);
        step("run_fff8", 0, 1, 1, 0, 32'h0,        1,   32'hFFFF_FFFC,instr_at(32'hFFFF_FFF8),32'hFFFF_FFFC,1, 2, 1);
        step("wrap",     0, 1, 1, 0, 32'h0,        1,   32'h0,        instr_at(32'hFFFF_FFFC),32'h0,       1, 3, 1);
        for (int k = 0; k < 20; k++) begin
            step("sat_run", 0, 1, 1, 0, 32'h0, 1,
                 32'(4 * (k + 1)), instr_at(32'(4 * k)), 32'(4 * (k + 1)), 1, 4 + k, 1);
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
